m_unit_iter: RTL and testbench
==============================

# m_unit_iter

Iterative, parametrised RV32M/RV64M multiply/divide unit that executes every `m_op_e` operation over several cycles. It uses a valid/ready handshake on both the input and output sides. It sits beside the ALU in the execute stage and feeds the `WB_M_UNIT` writeback source. Each cycle it retires `RADIX_BITS` bits of multiplier or quotient, and it resolves RISC-V divide corner cases on a single-cycle fast path.

## Interface
- `XLEN`, 32: operand and result width; must be a multiple of `RADIX_BITS`.
- `RADIX_BITS`, 1: bits processed per CALC cycle; legal values are 1, 2, 4.
- `TAG_W`, 5: width of the opaque tag (destination register) carried alongside the operation.
- `clk_i`  in  1  clock; all state is sampled on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  unit can accept a request; high only in IDLE.
- `op_i`  in  3  operation, encoded as `m_op_e`.
- `a_i`  in  XLEN  rs1 operand.
- `b_i`  in  XLEN  rs2 operand.
- `tag_i`  in  TAG_W  tag passed through unchanged.
- `flush_i`  in  1  abort the in-flight operation.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  consumer accepts the result.
- `result_o`  out  XLEN  result.
- `tag_o`  out  TAG_W  tag of the result.
- `busy_o`  out  1  high in CALC or DONE.

## Operation
- States are IDLE, CALC and DONE. Reset enters IDLE with `valid_o`=0, `ready_o`=1, `busy_o`=0, `result_o`=0, `tag_o`=0 and all internal counters and registers cleared.
- **IDLE:** on `valid_i && ready_o`, latch `op_i`, `tag_i` and the operand magnitudes.
  - Sign handling: MULH takes |a| and |b|; MULHSU takes |a| and b unsigned; DIV and REM take |a| and |b|. The result sign is latched.
  - If the op is a fast-path case (below), load `result_o` and go to DONE. Otherwise clear the iteration counter and go to CALC.
- **CALC:** runs N = XLEN/RADIX_BITS iterations.
  - Multiply is shift-add on a 2·XLEN accumulator, consuming RADIX_BITS multiplier bits per cycle (LSB first).
  - Divide is restoring division, producing RADIX_BITS quotient bits per cycle (MSB first) with an XLEN+1-bit partial remainder.
  - After iteration N, go to DONE and register `result_o`:
    - MUL: low XLEN bits of the product.
    - MULH, MULHSU, MULHU: high XLEN bits, using the two's-complement of the full 2·XLEN product when the latched sign is negative.
    - DIV, DIVU: quotient, negated if the operand signs differ (DIV only).
    - REM, REMU: remainder, carrying the sign of a (REM only).
- **DONE:** `valid_o`=1. On `ready_i`, go to IDLE.
- **Fast path:** all fast-path results are available in DONE one cycle after accept.
  - Divide by zero (b=0): DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (a = most negative value, b = −1): DIV gives a; REM gives 0.
  - a=0 or b=0 on any multiply op gives 0.
- **flush_i:** in CALC or DONE, go to IDLE on the next edge; no `valid_o` is produced for the flushed op. In IDLE, flush has priority over accept, so a request presented with flush is dropped.
- A new request can be accepted only in IDLE. Ops are never overlapped.

## Timing
- Accept edge is cycle 0.
- Iterative ops spend cycles 1..N in CALC, and `valid_o` rises in cycle N+1. With defaults, valid_o is in cycle 33.
- Fast-path ops have `valid_o` in cycle 1.
- `ready_o` is 0 from cycle 1 until the cycle after the output handshake. There is no same-cycle accept-after-retire: the minimum spacing between back-to-back requests is N+2 cycles.
- While `valid_o`=1 and `ready_i`=0, `result_o` and `tag_o` are held stable.
- `ready_o`, `valid_o` and `busy_o` are decoded from registered state only; there are no combinational input-to-output paths.
- Asynchronous reset mid-operation forces IDLE immediately with all outputs at their reset values. The first accept is possible on the first edge after `rst_i` deasserts.

## Test plan
1. **MUL 7 × −3, default parameters:** `result_o`=0xFFFFFFEB, `valid_o` in cycle 33, `tag_o` equals `tag_i`.
2. **High-product variants:**
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
   - Repeat all three with RADIX_BITS=4: same results, with `valid_o` in cycle 9.
3. **Signed division of −7 by 2:** DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF.
4. **Fast path, all in cycle 1:**
   - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
5. **Backpressure:** hold `ready_i`=0 for 5 cycles after `valid_o`. `result_o` stays stable, `ready_o` stays 0, and there is exactly one transfer. The next request is accepted in the cycle after the transfer.
6. **Flush and reset:**
   - Assert `flush_i` in cycle 10 of a DIVU: the unit is in IDLE in cycle 11 and `valid_o` never asserts.
   - Assert `rst_i` mid-CALC: outputs go to reset values immediately. A subsequent MUL 3 × 4 returns 12.

Source files
------------

// File: rtl/m_unit_iter_if.sv
// Request/response bundle of the iterative multiply/divide unit.
// Signal suffixes are named from the unit's point of view.
interface m_unit_iter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       op_i;
    logic [XLEN-1:0]  a_i;
    logic [XLEN-1:0]  b_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    modport slave (
        input  valid_i, op_i, a_i, b_i, tag_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, tag_o, busy_o
    );

    modport master (
        output valid_i, op_i, a_i, b_i, tag_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o, busy_o
    );
endinterface

// File: rtl/m_unit_iter.sv
// Iterative RV32M/RV64M multiply/divide unit. Shift-add multiply and restoring
// divide retire RADIX_BITS bits per cycle; divide corner cases and zero
// multiplies bypass the iteration and complete one cycle after accept.
module m_unit_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RADIX_BITS = 1,
    parameter int unsigned TAG_W      = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    m_unit_iter_if.slave bus
);
    localparam int unsigned N    = XLEN / RADIX_BITS;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } m_op_e;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q;
    m_op_e             op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   result_q;
    logic [CntW-1:0]   cnt_q;

    m_op_e             op_in;
    logic              a_neg, b_neg, a_zero, b_zero, ovf_in;
    logic [XLEN-1:0]   a_abs, b_abs, in_a, in_b;
    logic              in_neg;
    logic              fast_in;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN:0]     sum, rem_sh;
    logic [XLEN-1:0]   hi, lo, hi_neg, fin;

    // Accept-side decode: operand magnitudes, result sign and fast-path result.
    always_comb begin
        op_in  = m_op_e'(bus.op_i);
        a_neg  = bus.a_i[XLEN-1];
        b_neg  = bus.b_i[XLEN-1];
        a_abs  = a_neg ? -bus.a_i : bus.a_i;
        b_abs  = b_neg ? -bus.b_i : bus.b_i;
        a_zero = (bus.a_i == '0);
        b_zero = (bus.b_i == '0);
        ovf_in = (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_i == '1);
        in_a   = bus.a_i;
        in_b   = bus.b_i;
        in_neg = 1'b0;
        case (op_in)
            OpMulh:   begin in_a = a_abs; in_b = b_abs; in_neg = a_neg ^ b_neg; end
            OpMulhsu: begin in_a = a_abs; in_neg = a_neg; end
            OpDiv:    begin in_a = a_abs; in_b = b_abs; in_neg = a_neg ^ b_neg; end
            OpRem:    begin in_a = a_abs; in_b = b_abs; in_neg = a_neg; end
            default:  ;
        endcase
        fast_in  = 1'b0;
        fast_res = '0;
        // op[2] selects divide; op[1] selects remainder; op[0] selects unsigned
        if (!bus.op_i[2]) begin
            fast_in = a_zero | b_zero;
        end else if (b_zero) begin
            fast_in  = 1'b1;
            fast_res = bus.op_i[1] ? bus.a_i : '1;
        end else if (ovf_in && !bus.op_i[0]) begin
            fast_in  = 1'b1;
            fast_res = bus.op_i[1] ? '0 : bus.a_i;
        end
    end

    // One CALC cycle: RADIX_BITS shift-add or restoring-divide steps.
    always_comb begin
        acc_d  = acc_q;
        rem_d  = rem_q;
        sum    = '0;
        rem_sh = '0;
        for (int unsigned r = 0; r < RADIX_BITS; r++) begin
            if (!op_q[2]) begin
                sum   = {1'b0, acc_d[2*XLEN-1:XLEN]} + (acc_d[0] ? {1'b0, opb_q} : '0);
                acc_d = {sum, acc_d[XLEN-1:1]};
            end else begin
                rem_sh = {rem_d, acc_d[XLEN-1]};
                acc_d[XLEN-1:0] = {acc_d[XLEN-2:0], 1'b0};
                if (rem_sh >= {1'b0, opb_q}) begin
                    rem_sh   = rem_sh - {1'b0, opb_q};
                    acc_d[0] = 1'b1;
                end
                rem_d = rem_sh[XLEN-1:0];
            end
        end
    end

    // Final result selection from the last iteration's state.
    always_comb begin
        hi = acc_d[2*XLEN-1:XLEN];
        lo = acc_d[XLEN-1:0];
        // High half of the negated 2*XLEN product: carry into hi only if lo is zero
        hi_neg = ~hi + XLEN'(lo == '0);
        case (op_q)
            OpMul:                     fin = lo;
            OpMulh, OpMulhsu, OpMulhu: fin = neg_q ? hi_neg : hi;
            OpDiv, OpDivu:             fin = neg_q ? -lo : lo;
            default:                   fin = neg_q ? -rem_d : rem_d;
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.valid_i && !bus.flush_i) begin
                        op_q  <= op_in;
                        tag_q <= bus.tag_i;
                        neg_q <= in_neg;
                        acc_q <= {{XLEN{1'b0}}, in_a};
                        opb_q <= in_b;
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (fast_in) begin
                            result_q <= fast_res;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntW'(N - 1)) begin
                            result_q <= fin;
                            state_q  <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (bus.flush_i || bus.ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready_o  = (state_q == StIdle);
    assign bus.valid_o  = (state_q == StDone);
    assign bus.busy_o   = (state_q != StIdle);
    assign bus.result_o = result_q;
    assign bus.tag_o    = tag_q;
endmodule

// File: tb/tb_m_unit_iter.sv
// Bench for m_unit_iter: radix-1 and radix-4 instances share one stimulus
// stream and are checked against a 64-bit arithmetic reference model.
module tb_m_unit_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        valid, flush, rdy;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag;

    m_unit_iter_if #(.XLEN(32), .TAG_W(5)) if1 ();
    m_unit_iter_if #(.XLEN(32), .TAG_W(5)) if4 ();

    assign if1.valid_i = valid;
    assign if1.op_i    = op;
    assign if1.a_i     = a;
    assign if1.b_i     = b;
    assign if1.tag_i   = tag;
    assign if1.flush_i = flush;
    assign if1.ready_i = rdy;
    assign if4.valid_i = valid;
    assign if4.op_i    = op;
    assign if4.a_i     = a;
    assign if4.b_i     = b;
    assign if4.tag_i   = tag;
    assign if4.flush_i = flush;
    assign if4.ready_i = rdy;

    m_unit_iter #(.XLEN(32), .RADIX_BITS(1), .TAG_W(5)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    m_unit_iter #(.XLEN(32), .RADIX_BITS(4), .TAG_W(5)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if4.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // RISC-V M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f_op, input logic [31:0] x,
                                               input logic [31:0] y);
        longint          sx, sy, sp;
        longint unsigned ux, uy, up;
        logic [31:0]     res;
        logic            ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        res = '0;
        case (f_op)
            3'd0: begin up = ux * uy; res = up[31:0]; end
            3'd1: begin sp = sx * sy; res = sp[63:32]; end
            3'd2: begin sp = sx * longint'(uy); res = sp[63:32]; end
            3'd3: begin up = ux * uy; res = up[63:32]; end
            3'd4: begin
                if (y == 0) res = 32'hFFFF_FFFF;
                else if (ovf) res = x;
                else begin sp = sx / sy; res = sp[31:0]; end
            end
            3'd5: res = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) res = x;
                else if (ovf) res = 32'd0;
                else begin sp = sx % sy; res = sp[31:0]; end
            end
            default: res = (y == 0) ? x : x % y;
        endcase
        return res;
    endfunction

    function automatic bit ref_fast(input logic [2:0] f_op, input logic [31:0] x,
                                    input logic [31:0] y);
        if (f_op < 3'd4) return (x == 0) || (y == 0);
        if (y == 0) return 1'b1;
        return ((f_op == 3'd4) || (f_op == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op to both units (entered and left at a negedge) and check both results.
    task automatic do_op(input string name, input logic [2:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, input logic [4:0] t_tag, input int hold);
        logic [31:0] exp_res, r1, r4;
        logic [4:0]  g1, g4;
        int          exp_lat1, exp_lat4, lat1, lat4, xf1, xf4, c;
        bit          fast, bad1, bad4;
        exp_res  = ref_result(t_op, t_a, t_b);
        fast     = ref_fast(t_op, t_a, t_b);
        exp_lat1 = fast ? 1 : 33;
        exp_lat4 = fast ? 1 : 9;
        c = 0;
        while (!(if1.ready_o && if4.ready_o) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check_eq({name, " idle"}, {if1.ready_o, if4.ready_o}, 2'b11);
        valid = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        tag   = t_tag;
        rdy   = (hold == 0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        check_eq({name, " accept"}, {if1.busy_o, if4.busy_o, if1.ready_o, if4.ready_o}, 4'b1100);
        lat1 = -1; lat4 = -1; xf1 = 0; xf4 = 0; bad1 = 0; bad4 = 0; c = 0;
        r1 = 'x; r4 = 'x; g1 = 'x; g4 = 'x;
        while (!(xf1 > 0 && xf4 > 0) && c < 80) begin
            @(negedge clk);
            c++;
            if (if1.valid_o) begin
                if (lat1 < 0) begin lat1 = c; r1 = if1.result_o; g1 = if1.tag_o; end
                else if (if1.result_o !== r1 || if1.tag_o !== g1) bad1 = 1;
            end
            if (if4.valid_o) begin
                if (lat4 < 0) begin lat4 = c; r4 = if4.result_o; g4 = if4.tag_o; end
                else if (if4.result_o !== r4 || if4.tag_o !== g4) bad4 = 1;
            end
            if (xf1 == 0 && (if1.ready_o || !if1.busy_o)) bad1 = 1;
            if (xf4 == 0 && (if4.ready_o || !if4.busy_o)) bad4 = 1;
            if (hold > 0) rdy = (lat1 >= 0) && (c >= lat1 + hold);
            if (if1.valid_o && rdy) xf1++;
            if (if4.valid_o && rdy) xf4++;
        end
        rdy = 1'b1;
        check_eq({name, " lat r1"}, lat1, exp_lat1);
        check_eq({name, " lat r4"}, lat4, exp_lat4);
        check_eq({name, " res r1"}, r1, exp_res);
        check_eq({name, " res r4"}, r4, exp_res);
        check_eq({name, " tag"}, {g1, g4}, {t_tag, t_tag});
        check_eq({name, " xfers"}, {xf1[7:0], xf4[7:0]}, 16'h0101);
        check_eq({name, " hold stable"}, {bad1, bad4}, 2'b00);
        @(negedge clk);
        check_eq({name, " retire"}, {if1.ready_o, if4.ready_o, if1.valid_o, if4.valid_o}, 4'b1100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst = 1'b1; valid = 1'b0; flush = 1'b0; rdy = 1'b1;
        op = '0; a = '0; b = '0; tag = '0;
        repeat (2) @(negedge clk);
        check_eq("reset ctl", {if1.valid_o, if1.ready_o, if1.busy_o,
                               if4.valid_o, if4.ready_o, if4.busy_o}, 6'b010010);
        check_eq("reset data", {if1.result_o, if1.tag_o, if4.tag_o}, 42'd0);
        rst = 1'b0;

        do_op("mul 7x-3",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'h0B, 0);
        do_op("mulh min",    3'd1, 32'h8000_0000, 32'h8000_0000, 5'h01, 0);
        do_op("mulhu ones",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, 0);
        do_op("mulhsu ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 0);
        do_op("div -7/2",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'h04, 0);
        do_op("rem -7/2",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'h05, 0);
        do_op("divu 5/0",    3'd5, 32'd5,         32'd0,         5'h06, 0);
        do_op("remu 5/0",    3'd7, 32'd5,         32'd0,         5'h07, 0);
        do_op("div ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'h08, 0);
        do_op("rem ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'h09, 0);
        do_op("mul zero",    3'd0, 32'd0,         32'h1234_5678, 5'h0A, 0);
        do_op("bp divu",     3'd5, 32'hDEAD_BEEF, 32'd77,        5'h1C, 5);
        do_op("after bp",    3'd1, 32'hFFFF_FFF0, 32'd3,         5'h1D, 0);

        for (int i = 0; i < 40; i++) begin
            do_op("rand", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  5'($urandom), (i % 7 == 3) ? int'($urandom_range(1, 3)) : 0);
        end

        // Flush a DIVU in cycle 10.
        valid = 1'b1; op = 3'd5; a = $urandom; b = $urandom | 32'd1; tag = 5'h11; rdy = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (if1.valid_o) seen = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush idle", {if1.ready_o, if1.busy_o, if4.ready_o, if4.busy_o}, 4'b1010);
        rdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if1.valid_o || if4.valid_o) seen = 1'b1;
        end
        check_eq("flush no valid", seen, 1'b0);

        // A request presented together with flush in IDLE is dropped.
        valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        valid = 1'b0; flush = 1'b0;
        check_eq("flush drops req", {if1.busy_o, if4.busy_o, if1.ready_o, if4.ready_o}, 4'b0011);
        @(negedge clk);

        // Asynchronous reset mid-CALC.
        valid = 1'b1; op = 3'd0; a = 32'h0001_2345; b = 32'h0000_0777; tag = 5'h15; rdy = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst async ctl", {if1.valid_o, if1.ready_o, if1.busy_o,
                                   if4.valid_o, if4.ready_o, if4.busy_o}, 6'b010010);
        check_eq("rst async data", {if1.result_o, if4.result_o, if1.tag_o, if4.tag_o}, 74'd0);
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_op("mul 3x4", 3'd0, 32'd3, 32'd4, 5'h12, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
